parity_gen: RTL and testbench

PARITY_GEN -- requirements
Module: parity_gen

---
 rtl/fifo_package.sv | 17 +
 rtl/parity_skid_buf.sv | 83 ++++++++
 rtl/parity_gen.sv | 93 +++++++++
 tb/tb_parity_gen.sv | 413 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_package.sv
`default_nettype none
// fifo_package: shared defaults and buffer-state encoding for parity_gen.
// Revision 1.0
package fifo_package;

  localparam int    DATA_WIDTH  = 9;
  localparam string PARITY_BIT  = "MSB";
  localparam string PARITY_TYPE = "EVEN";

  typedef enum logic [1:0] {
    BUF_EMPTY = 2'd0,
    BUF_ONE   = 2'd1,
    BUF_FULL  = 2'd2
  } buf_state_e;

endpackage
`default_nettype wire

// File: rtl/parity_skid_buf.sv
`default_nettype none
// parity_skid_buf: 2-entry (main, skid) output buffer with fully registered outputs.
// Revision 1.0
module parity_skid_buf
  import fifo_package::*;
#(
  parameter int WIDTH = DATA_WIDTH + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_data_i,
  input  logic             in_valid_i,
  output logic             in_grant_o,
  output logic [WIDTH-1:0] out_data_o,
  output logic             out_valid_o,
  input  logic             out_grant_i
);

  buf_state_e       state_q, state_d;
  logic [WIDTH-1:0] main_q, main_d;
  logic [WIDTH-1:0] skid_q, skid_d;
  logic             grant_q, grant_d;
  logic             accept;
  logic             pop;

  assign accept = in_valid_i && grant_q;
  assign pop    = (state_q != BUF_EMPTY) && out_grant_i;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= BUF_EMPTY;
      main_q  <= '0;
      skid_q  <= '0;
      grant_q <= 1'b0;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
      grant_q <= grant_d;
    end
  end

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    case (state_q)
      BUF_EMPTY: begin
        if (accept) begin
          state_d = BUF_ONE;
          main_d  = in_data_i;
        end
      end
      BUF_ONE: begin
        if (accept && pop) begin
          main_d = in_data_i;
        end else if (accept) begin
          state_d = BUF_FULL;
          skid_d  = in_data_i;
        end else if (pop) begin
          state_d = BUF_EMPTY;
        end
      end
      BUF_FULL: begin
        // grant is low here, so only a pop can move the buffer
        if (pop) begin
          state_d = BUF_ONE;
          main_d  = skid_q;
        end
      end
      default: state_d = BUF_EMPTY;
    endcase
    grant_d = (state_d != BUF_FULL);
  end

  always_comb begin
    out_valid_o = (state_q != BUF_EMPTY);
    out_data_o  = main_q;
    in_grant_o  = grant_q;
  end

endmodule
`default_nettype wire

// File: rtl/parity_gen.sv
`default_nettype none
// parity_gen: appends an even/odd parity bit to each upstream word and feeds a FIFO push port.
// Revision 1.0
module parity_gen #(
  parameter int    DATA_WIDTH  = fifo_package::DATA_WIDTH,
  parameter string PARITY_BIT  = fifo_package::PARITY_BIT,
  parameter string PARITY_TYPE = fifo_package::PARITY_TYPE
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-2:0] data_i,
  input  logic                  valid_i,
  output logic                  grant_o,
  input  logic                  err_inject_i,
  output logic [DATA_WIDTH-1:0] data_o,
  output logic                  push_valid_o,
  input  logic                  push_grant_i,
  output logic [15:0]           word_cnt_o,
  output logic [7:0]            err_cnt_o
);
  import fifo_package::*;

  logic                  parity_raw;
  logic                  parity;
  logic [DATA_WIDTH-1:0] packed_word;
  logic [DATA_WIDTH:0]   entry_out;
  logic                  entry_err;
  logic                  push;
  logic [15:0]           word_cnt_q, word_cnt_d;
  logic [7:0]            err_cnt_q, err_cnt_d;

  generate
    if (PARITY_TYPE == "ODD") begin : g_odd
      assign parity_raw = ~^data_i;
    end else begin : g_even
      assign parity_raw = ^data_i;
    end
  endgenerate

  assign parity = parity_raw ^ err_inject_i;

  generate
    if (PARITY_BIT == "LSB") begin : g_lsb
      assign packed_word = {data_i, parity};
    end else begin : g_msb
      assign packed_word = {parity, data_i};
    end
  endgenerate

  // Each entry carries its injected-error flag above the packed word
  parity_skid_buf #(
    .WIDTH (DATA_WIDTH + 1)
  ) u_buf (
    .clk         (clk),
    .rst         (rst),
    .in_data_i   ({err_inject_i, packed_word}),
    .in_valid_i  (valid_i),
    .in_grant_o  (grant_o),
    .out_data_o  (entry_out),
    .out_valid_o (push_valid_o),
    .out_grant_i (push_grant_i)
  );

  assign data_o    = entry_out[DATA_WIDTH-1:0];
  assign entry_err = entry_out[DATA_WIDTH];
  assign push      = push_valid_o && push_grant_i;

  always_comb begin
    word_cnt_d = word_cnt_q;
    err_cnt_d  = err_cnt_q;
    if (push) begin
      word_cnt_d = word_cnt_q + 16'd1;
      if (entry_err && (err_cnt_q != 8'hFF)) begin
        err_cnt_d = err_cnt_q + 8'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      word_cnt_q <= '0;
      err_cnt_q  <= '0;
    end else begin
      word_cnt_q <= word_cnt_d;
      err_cnt_q  <= err_cnt_d;
    end
  end

  assign word_cnt_o = word_cnt_q;
  assign err_cnt_o  = err_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_parity_gen.sv
`default_nettype none
// tb_parity_gen: randomized scoreboard bench for parity_gen (MSB/EVEN and LSB/ODD instances).
// Revision 1.0
module tb_parity_gen;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  data_i = '0;
  logic        valid_i = 1'b0;
  logic        err_inject_i = 1'b0;
  logic        push_grant_i = 1'b0;

  logic        grant_o, push_valid_o;
  logic [8:0]  data_o;
  logic [15:0] word_cnt_o;
  logic [7:0]  err_cnt_o;

  logic        grant_lo, push_valid_lo;
  logic [8:0]  data_lo;
  logic [15:0] word_cnt_lo;
  logic [7:0]  err_cnt_lo;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [7:0] d;
    logic       inj;
  } entry_t;

  entry_t     q[$];
  int         m_words = 0;
  int         m_errs = 0;
  logic [8:0] prev_data = '0;
  bit         prev_stall = 1'b0;

  always #5 clk = ~clk;

  parity_gen u_dut (
    .clk          (clk),
    .rst          (rst),
    .data_i       (data_i),
    .valid_i      (valid_i),
    .grant_o      (grant_o),
    .err_inject_i (err_inject_i),
    .data_o       (data_o),
    .push_valid_o (push_valid_o),
    .push_grant_i (push_grant_i),
    .word_cnt_o   (word_cnt_o),
    .err_cnt_o    (err_cnt_o)
  );

  parity_gen #(
    .DATA_WIDTH  (9),
    .PARITY_BIT  ("LSB"),
    .PARITY_TYPE ("ODD")
  ) u_lo (
    .clk          (clk),
    .rst          (rst),
    .data_i       (data_i),
    .valid_i      (valid_i),
    .grant_o      (grant_lo),
    .err_inject_i (err_inject_i),
    .data_o       (data_lo),
    .push_valid_o (push_valid_lo),
    .push_grant_i (push_grant_i),
    .word_cnt_o   (word_cnt_lo),
    .err_cnt_o    (err_cnt_lo)
  );

  // Parity bit chosen so the whole word has an even (or odd) count of ones
  function automatic logic [8:0] expect_word(logic [7:0] d, logic inj, bit lsb, bit odd);
    int ones;
    bit p;
    ones = $countones(d);
    p = odd ? ((ones % 2) == 0) : ((ones % 2) == 1);
    p = p ^ inj;
    return lsb ? {d, p} : {p, d};
  endfunction

  // One clock of traffic: scoreboard bookkeeping before the edge, counters after it
  task automatic run_cycle();
    entry_t e;
    bit acc, pop;
    acc = valid_i && grant_o;
    pop = push_valid_o && push_grant_i;
    checks++;
    if (push_valid_o !== (q.size() != 0)) begin
      failures++;
      $display("FAIL push_valid: got %b expected %b", push_valid_o, (q.size() != 0));
    end
    checks++;
    if (grant_o !== (q.size() < 2)) begin
      failures++;
      $display("FAIL grant: got %b expected %b (occupancy %0d)", grant_o, (q.size() < 2), q.size());
    end
    if (prev_stall) begin
      checks++;
      if (data_o !== prev_data) begin
        failures++;
        $display("FAIL hold_stable: got %h expected %h", data_o, prev_data);
      end
    end
    if (pop) begin
      checks++;
      if (q.size() == 0) begin
        failures++;
        $display("FAIL pop_order: got push with data %h expected no word", data_o);
      end else begin
        e = q.pop_front();
        if (data_o !== expect_word(e.d, e.inj, 1'b0, 1'b0)) begin
          failures++;
          $display("FAIL pop_msb_even: got %h expected %h", data_o, expect_word(e.d, e.inj, 1'b0, 1'b0));
        end
        checks++;
        if (data_lo !== expect_word(e.d, e.inj, 1'b1, 1'b1)) begin
          failures++;
          $display("FAIL pop_lsb_odd: got %h expected %h", data_lo, expect_word(e.d, e.inj, 1'b1, 1'b1));
        end
        m_words++;
        if (e.inj && m_errs < 255) m_errs++;
      end
    end
    if (acc) begin
      e.d = data_i;
      e.inj = err_inject_i;
      q.push_back(e);
    end
    prev_stall = push_valid_o && !push_grant_i;
    prev_data  = data_o;
    @(posedge clk); #1;
    checks++;
    if (word_cnt_o !== 16'(m_words % 65536)) begin
      failures++;
      $display("FAIL word_cnt: got %0d expected %0d", word_cnt_o, m_words % 65536);
    end
    checks++;
    if (err_cnt_o !== 8'(m_errs)) begin
      failures++;
      $display("FAIL err_cnt: got %0d expected %0d", err_cnt_o, m_errs);
    end
  endtask

  task automatic drain();
    int guard;
    valid_i = 1'b0;
    err_inject_i = 1'b0;
    push_grant_i = 1'b1;
    guard = 0;
    while (q.size() != 0 && guard < 20) begin
      run_cycle();
      guard++;
    end
    checks++;
    if (q.size() != 0) begin
      failures++;
      $display("FAIL drain_timeout: got %0d words left expected 0", q.size());
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    valid_i = 1'b0;
    err_inject_i = 1'b0;
    push_grant_i = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (push_valid_o !== 1'b0 || push_valid_lo !== 1'b0) begin
      failures++;
      $display("FAIL reset_push_valid: got %b/%b expected 0", push_valid_o, push_valid_lo);
    end
    checks++;
    if (data_o !== 9'h000) begin
      failures++;
      $display("FAIL reset_data: got %h expected 000", data_o);
    end
    checks++;
    if (word_cnt_o !== 16'h0 || err_cnt_o !== 8'h0) begin
      failures++;
      $display("FAIL reset_counters: got %h/%h expected 0/0", word_cnt_o, err_cnt_o);
    end
    checks++;
    if (grant_o !== 1'b0) begin
      failures++;
      $display("FAIL reset_grant: got %b expected 0", grant_o);
    end
    rst = 1'b0;
    q.delete();
    m_words = 0;
    m_errs = 0;
    prev_stall = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (grant_o !== 1'b1 || grant_lo !== 1'b1) begin
      failures++;
      $display("FAIL post_reset_grant: got %b/%b expected 1", grant_o, grant_lo);
    end
  endtask

  task automatic test_basic();
    push_grant_i = 1'b1;
    data_i = 8'hA5;
    valid_i = 1'b1;
    run_cycle();
    valid_i = 1'b0;
    checks++;
    if (data_o !== 9'h0A5 || push_valid_o !== 1'b1) begin
      failures++;
      $display("FAIL basic_msb_even: got %h valid %b expected 0a5 valid 1", data_o, push_valid_o);
    end
    checks++;
    if (data_lo !== 9'h14B) begin
      failures++;
      $display("FAIL basic_lsb_odd: got %h expected 14b", data_lo);
    end
    run_cycle();
    checks++;
    if (word_cnt_o !== 16'd1 || word_cnt_lo !== 16'd1) begin
      failures++;
      $display("FAIL basic_word_cnt: got %0d/%0d expected 1", word_cnt_o, word_cnt_lo);
    end
  endtask

  task automatic test_variants();
    push_grant_i = 1'b1;
    data_i = 8'h01;
    valid_i = 1'b1;
    err_inject_i = 1'b0;
    run_cycle();
    checks++;
    if (data_lo !== 9'h002 || data_o !== 9'h101) begin
      failures++;
      $display("FAIL variant_plain: got %h/%h expected 002/101", data_lo, data_o);
    end
    err_inject_i = 1'b1;
    run_cycle();
    checks++;
    if (data_lo !== 9'h003) begin
      failures++;
      $display("FAIL variant_inject: got %h expected 003", data_lo);
    end
    drain();
    checks++;
    if (err_cnt_o !== 8'd1 || err_cnt_lo !== 8'd1) begin
      failures++;
      $display("FAIL variant_err_cnt: got %0d/%0d expected 1", err_cnt_o, err_cnt_lo);
    end
  endtask

  task automatic test_backpressure();
    int base;
    base = m_words;
    push_grant_i = 1'b0;
    valid_i = 1'b1;
    data_i = 8'd1;
    run_cycle();
    data_i = 8'd2;
    run_cycle();
    checks++;
    if (grant_o !== 1'b0) begin
      failures++;
      $display("FAIL bp_grant_low: got %b expected 0", grant_o);
    end
    data_i = 8'd3;
    repeat (3) run_cycle();
    checks++;
    if (data_o !== expect_word(8'd1, 1'b0, 1'b0, 1'b0)) begin
      failures++;
      $display("FAIL bp_head: got %h expected %h", data_o, expect_word(8'd1, 1'b0, 1'b0, 1'b0));
    end
    push_grant_i = 1'b1;
    repeat (2) run_cycle();
    drain();
    checks++;
    if (word_cnt_o !== 16'(base + 3)) begin
      failures++;
      $display("FAIL bp_word_cnt: got %0d expected %0d", word_cnt_o, base + 3);
    end
  endtask

  task automatic test_streaming();
    int base;
    base = m_words;
    push_grant_i = 1'b1;
    valid_i = 1'b1;
    for (int i = 0; i < 20; i++) begin
      data_i = 8'($urandom);
      run_cycle();
      checks++;
      if (push_valid_o !== 1'b1 || grant_o !== 1'b1) begin
        failures++;
        $display("FAIL stream_one_state: got valid %b grant %b expected 1/1", push_valid_o, grant_o);
      end
    end
    drain();
    checks++;
    if (word_cnt_o !== 16'(base + 20)) begin
      failures++;
      $display("FAIL stream_word_cnt: got %0d expected %0d", word_cnt_o, base + 20);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      valid_i = ($urandom_range(0, 3) != 0);
      data_i = 8'($urandom);
      err_inject_i = ($urandom_range(0, 7) == 0);
      push_grant_i = ($urandom_range(0, 2) != 0);
      run_cycle();
    end
    drain();
  endtask

  task automatic test_reset_full();
    push_grant_i = 1'b0;
    valid_i = 1'b1;
    err_inject_i = 1'b1;
    data_i = 8'h3C;
    repeat (3) run_cycle();
    checks++;
    if (grant_o !== 1'b0 || push_valid_o !== 1'b1) begin
      failures++;
      $display("FAIL full_before_reset: got grant %b valid %b expected 0/1", grant_o, push_valid_o);
    end
    rst = 1'b1;
    valid_i = 1'b0;
    err_inject_i = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (push_valid_o !== 1'b0) begin
      failures++;
      $display("FAIL full_reset_valid: got %b expected 0", push_valid_o);
    end
    checks++;
    if (word_cnt_o !== 16'h0 || err_cnt_o !== 8'h0) begin
      failures++;
      $display("FAIL full_reset_counters: got %h/%h expected 0/0", word_cnt_o, err_cnt_o);
    end
    rst = 1'b0;
    q.delete();
    m_words = 0;
    m_errs = 0;
    prev_stall = 1'b0;
    @(posedge clk); #1;
    push_grant_i = 1'b1;
    repeat (5) run_cycle();
  endtask

  task automatic test_counters();
    int accepted;
    int guard;
    accepted = 0;
    guard = 0;
    push_grant_i = 1'b1;
    err_inject_i = 1'b0;
    while (accepted < 65535 && guard < 70000) begin
      valid_i = 1'b1;
      data_i = 8'($urandom);
      if (valid_i && grant_o) accepted++;
      run_cycle();
      guard++;
    end
    drain();
    checks++;
    if (word_cnt_o !== 16'hFFFF) begin
      failures++;
      $display("FAIL cnt_preload: got %h expected ffff", word_cnt_o);
    end
    valid_i = 1'b1;
    run_cycle();
    drain();
    checks++;
    if (word_cnt_o !== 16'h0000) begin
      failures++;
      $display("FAIL cnt_wrap: got %h expected 0000", word_cnt_o);
    end

    test_reset();
    accepted = 0;
    guard = 0;
    push_grant_i = 1'b1;
    err_inject_i = 1'b1;
    while (accepted < 256 && guard < 1000) begin
      valid_i = 1'b1;
      data_i = 8'($urandom);
      if (valid_i && grant_o) accepted++;
      run_cycle();
      guard++;
    end
    drain();
    checks++;
    if (err_cnt_o !== 8'hFF || err_cnt_lo !== 8'hFF) begin
      failures++;
      $display("FAIL err_saturate: got %h/%h expected ff", err_cnt_o, err_cnt_lo);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_variants();
    test_backpressure();
    test_streaming();
    test_random();
    test_reset_full();
    test_counters();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
